// File: rtl/wb_port_arb_if.sv
// Bundle of the two write-back requester ports and the register-file/forwarding
// outputs of the write-port arbiter.
interface wb_port_arb_if #(
    parameter int XLEN = 32
);
    logic            ex_valid_i;
    logic [4:0]      ex_rd_i;
    logic [XLEN-1:0] ex_wdata_i;
    logic            ex_ready_o;

    logic            mc_valid_i;
    logic [4:0]      mc_rd_i;
    logic [XLEN-1:0] mc_wdata_i;
    logic            mc_ready_o;

    logic            rf_wen_o;
    logic [4:0]      rf_rd_o;
    logic [XLEN-1:0] rf_wdata_o;

    logic            fwd_valid_o;
    logic [4:0]      fwd_rd_o;
    logic [XLEN-1:0] fwd_data_o;

    logic [31:0]     wr_count_o;

    modport master (
        output ex_valid_i, ex_rd_i, ex_wdata_i,
        output mc_valid_i, mc_rd_i, mc_wdata_i,
        input  ex_ready_o, mc_ready_o,
        input  rf_wen_o, rf_rd_o, rf_wdata_o,
        input  fwd_valid_o, fwd_rd_o, fwd_data_o,
        input  wr_count_o
    );

    modport slave (
        input  ex_valid_i, ex_rd_i, ex_wdata_i,
        input  mc_valid_i, mc_rd_i, mc_wdata_i,
        output ex_ready_o, mc_ready_o,
        output rf_wen_o, rf_rd_o, rf_wdata_o,
        output fwd_valid_o, fwd_rd_o, fwd_data_o,
        output wr_count_o
    );
endinterface

// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: the in-order pipeline normally wins, the
// multi-cycle unit is forced through after STARVE_LIMIT consecutive stalls.
module wb_port_arb #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    wb_port_arb_if.slave bus
);
    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        FORCE_MC = 1'b1
    } arb_state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    arb_state_e      state_p0;
    logic [3:0]      wait_cnt_p0;

    logic            ex_gnt;
    logic            mc_gnt;
    logic            xfer;
    logic            wait_inc;
    logic [3:0]      wait_nxt;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_wdata;

    logic            wen_p1;
    logic [4:0]      rd_p1;
    logic [XLEN-1:0] wdata_p1;
    logic [31:0]     wr_cnt_p1;

    // Stage 0: grant decision, purely from valids, arbiter state and reset
    always_comb begin
        ex_gnt = 1'b0;
        mc_gnt = 1'b0;
        if (rst_ni) begin
            if (state_p0 == FORCE_MC && bus.mc_valid_i) begin
                mc_gnt = 1'b1;
            end else if (bus.ex_valid_i) begin
                ex_gnt = 1'b1;
            end else if (bus.mc_valid_i) begin
                mc_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        xfer      = ex_gnt | mc_gnt;
        wait_inc  = bus.mc_valid_i & ~mc_gnt;
        wait_nxt  = sat_inc4(wait_cnt_p0);
        sel_rd    = mc_gnt ? bus.mc_rd_i    : bus.ex_rd_i;
        sel_wdata = mc_gnt ? bus.mc_wdata_i : bus.ex_wdata_i;
    end

    // Stage 0 -> 1: arbiter state and the registered regfile write
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_p0    <= NORMAL;
            wait_cnt_p0 <= 4'd0;
            wen_p1      <= 1'b0;
            rd_p1       <= 5'd0;
            wdata_p1    <= '0;
            wr_cnt_p1   <= 32'd0;
        end else begin
            wait_cnt_p0 <= wait_inc ? wait_nxt : 4'd0;

            case (state_p0)
                NORMAL: begin
                    if (wait_inc && wait_nxt >= LIMIT) begin
                        state_p0 <= FORCE_MC;
                    end
                end
                FORCE_MC: begin
                    if (mc_gnt || !bus.mc_valid_i) begin
                        state_p0 <= NORMAL;
                    end
                end
                default: state_p0 <= NORMAL;
            endcase

            // rd=0 writes are consumed and counted but never enable the regfile
            wen_p1 <= xfer && (sel_rd != 5'd0);
            if (xfer) begin
                rd_p1     <= sel_rd;
                wdata_p1  <= sel_wdata;
                wr_cnt_p1 <= wr_cnt_p1 + 32'd1;
            end
        end
    end

    // Stage 1: outputs; reset kills a write pulse already in flight
    always_comb begin
        bus.ex_ready_o  = ex_gnt;
        bus.mc_ready_o  = mc_gnt;
        bus.rf_wen_o    = wen_p1 & rst_ni;
        bus.rf_rd_o     = rd_p1;
        bus.rf_wdata_o  = wdata_p1;
        bus.fwd_valid_o = wen_p1 & rst_ni;
        bus.fwd_rd_o    = rd_p1;
        bus.fwd_data_o  = wdata_p1;
        bus.wr_count_o  = wr_cnt_p1;
    end
endmodule
